huffman_decoder: RTL and testbench
==================================

Name: huffman_decoder

Overview:
- Receive side of the gray-level Huffman path: loads the six codewords HC1..HC6 and masks M1..M6 produced by the encoder, then decodes a serial bitstream (MSB of each codeword first) back into gray symbols 1..6.
- Sits downstream of the encoder / bit packer. Uses valid/ready on both the bit input and the symbol output.
- Also keeps a running count of decoded symbols.

Parameters:
- MAXLEN, 8, maximum codeword length in bits. Equals the HC/M width.
- CW, 8, width of the decoded-symbol counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- code_valid  in  1  one-cycle pulse; HC1..HC6 and M1..M6 are valid and must be latched
- HC1..HC6  in  8 each  right-aligned codeword for symbol i
- M1..M6  in  8 each  right-aligned mask of contiguous low ones; codeword length = popcount(Mi)
- bit_valid  in  1  serial bit present
- bit_in  in  1  serial bit
- bit_ready  out  1  decoder accepts a bit this cycle
- sym_valid  out  1  decoded symbol present
- sym  out  3  decoded symbol, 1..6
- sym_ready  in  1  downstream consumes the symbol
- err  out  1  sticky error flag
- err_type  out  2  01 = bad table, 10 = no codeword matched within MAXLEN bits
- dec_count  out  CW  number of symbols accepted downstream since the last load; wraps modulo 2^CW

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state = NO_TAB.
  - Outputs: bit_ready=0, sym_valid=0, sym=0, err=0, err_type=0, dec_count=0.
  - Internal: accumulator acc=0, length counter len=0, table registers=0.
  - Reset has priority over everything and may occur mid-decode; no partial state survives it.
- States:
  - NO_TAB: no table loaded; bit_ready=0.
  - RUN: table loaded; bit_ready = !sym_valid | sym_ready.
  - ERR: bit_ready=0; sym_valid=0.
- Table load, on code_valid in any state:
  - Latch HC/M into the table registers.
  - Clear acc, len, sym_valid, err, err_type and dec_count. A pending symbol is dropped.
  - Table check: every Mi must satisfy Mi!=0 and (Mi & (Mi+1))==0.
  - Check pass: next state RUN. Check fail: next state ERR with err=1, err_type=01.
  - code_valid has priority over a bit accepted in the same cycle; that bit is discarded.
- Bit accept, in RUN when bit_valid & bit_ready:
  - acc_n = {acc[6:0], bit_in}; len_n = len + 1.
  - Symbol i matches when popcount(Mi) == len_n and (acc_n & Mi) == HCi.
  - If several symbols match, the lowest i wins. The encoder guarantees a prefix-free table, so this only resolves a malformed table.
  - Match: sym <= i, sym_valid <= 1, acc <= 0, len <= 0.
  - No match and len_n < MAXLEN: acc <= acc_n, len <= len_n.
  - No match and len_n == MAXLEN: next state ERR, err=1, err_type=10, acc/len cleared, sym_valid unchanged.
- Latency: a bit accepted at cycle t that completes a codeword gives sym_valid=1 at t+1.
- Output handshake:
  - sym_valid and sym stay stable until sym_valid & sym_ready.
  - On that handshake, dec_count increments by 1 and wraps from 2^CW-1 to 0.
  - If a new codeword completes in the same cycle as the handshake, sym_valid stays 1 and sym takes the new value (back-to-back, one symbol per cycle for 1-bit codes).
  - While sym_valid & !sym_ready, bit_ready=0 and no bits are consumed.
- ERR state is left only by reset or code_valid. bit_valid is ignored while in ERR or NO_TAB.

Test Plan:
- Basic stream:
  - Load HC1=0/M1=01, HC2=02/M2=03, HC3=06/M3=07, HC4=0E/M4=0F, HC5=1E/M5=1F, HC6=1F/M6=1F.
  - Stream bits 0,10,110,1110,11110,11111 with sym_ready=1.
  - Expect sym = 1,2,3,4,5,6, each one cycle after its last bit; dec_count=6; err=0.
- Backpressure:
  - Same table; bits 0,0,10; hold sym_ready=0 after the first symbol.
  - Expect bit_ready=0 and sym=1 held. Release sym_ready: symbols 1,1,2 in order, none lost, dec_count=3.
- Bad table:
  - Load with M3=05 (non-contiguous mask).
  - Expect err=1, err_type=01, bit_ready=0. Reload a valid table: err=0, bit_ready=1.
- No-match overflow:
  - Load a table with all codes 1 bit long except an unused prefix (M1=01 HC1=0; M2..M6=03 with HC=01 duplicates); stream 8 consecutive 1s.
  - Expect err=1, err_type=10 after the 8th bit and no sym_valid.
- Reset mid-codeword:
  - Stream bits 1,1 (partial codeword), then assert reset.
  - Expect state NO_TAB and every output 0. Reload the table, send 0: sym=1, so no stale prefix remains.
- Reload during pending symbol:
  - Hold sym_valid=1 with sym_ready=0, then pulse code_valid.
  - Expect sym_valid=0 and dec_count=0 next cycle, and decoding restarts cleanly.

Source files
------------

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for gray symbols 1..6.
// Loads the codeword/mask table, then matches MSB-first bits against it.
module huffman_decoder #(
    parameter int MAXLEN = 8,
    parameter int CW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [MAXLEN-1:0] HC1,
    input  logic [MAXLEN-1:0] HC2,
    input  logic [MAXLEN-1:0] HC3,
    input  logic [MAXLEN-1:0] HC4,
    input  logic [MAXLEN-1:0] HC5,
    input  logic [MAXLEN-1:0] HC6,
    input  logic [MAXLEN-1:0] M1,
    input  logic [MAXLEN-1:0] M2,
    input  logic [MAXLEN-1:0] M3,
    input  logic [MAXLEN-1:0] M4,
    input  logic [MAXLEN-1:0] M5,
    input  logic [MAXLEN-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [2:0]        sym,
    input  logic              sym_ready,
    output logic              err,
    output logic [1:0]        err_type,
    output logic [CW-1:0]     dec_count
);

    localparam int LW = $clog2(MAXLEN + 1);
    localparam logic [MAXLEN-1:0] M_ONE = 1;
    localparam logic [LW-1:0] L_ONE = 1;
    localparam logic [LW-1:0] L_MAX = LW'(MAXLEN);
    localparam logic [CW-1:0] C_ONE = 1;

    typedef enum logic [1:0] {NO_TAB, RUN, ERR} state_t;

    state_t            r_state;
    logic [MAXLEN-1:0] r_hc [6];
    logic [MAXLEN-1:0] r_m  [6];
    logic [MAXLEN-1:0] r_acc;
    logic [LW-1:0]     r_len;

    logic [MAXLEN-1:0] w_hc_in [6];
    logic [MAXLEN-1:0] w_m_in  [6];
    logic [MAXLEN-1:0] w_acc_n;
    logic [LW-1:0]     w_len_n;
    logic              w_tab_ok;
    logic              w_match;
    logic [2:0]        w_idx;
    logic              w_accept;
    logic              w_hs;

    function automatic logic [LW-1:0] popcnt(input logic [MAXLEN-1:0] v);
        logic [LW-1:0] c;
        c = '0;
        for (int k = 0; k < MAXLEN; k++) c = c + LW'(v[k]);
        return c;
    endfunction

    assign w_hc_in[0] = HC1;
    assign w_hc_in[1] = HC2;
    assign w_hc_in[2] = HC3;
    assign w_hc_in[3] = HC4;
    assign w_hc_in[4] = HC5;
    assign w_hc_in[5] = HC6;
    assign w_m_in[0]  = M1;
    assign w_m_in[1]  = M2;
    assign w_m_in[2]  = M3;
    assign w_m_in[3]  = M4;
    assign w_m_in[4]  = M5;
    assign w_m_in[5]  = M6;

    assign bit_ready = (r_state == RUN) && (!sym_valid || sym_ready);
    assign w_accept  = bit_valid && bit_ready;
    assign w_hs      = sym_valid && sym_ready;
    assign w_acc_n   = {r_acc[MAXLEN-2:0], bit_in};
    assign w_len_n   = r_len + L_ONE;

    // A mask is legal when nonzero and a contiguous run of low ones.
    always_comb begin
        w_tab_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_m_in[i] == '0 || (w_m_in[i] & (w_m_in[i] + M_ONE)) != '0)
                w_tab_ok = 1'b0;
        end
    end

    // Scan downward so the lowest matching symbol index wins.
    always_comb begin
        w_match = 1'b0;
        w_idx   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (popcnt(r_m[i]) == w_len_n && (w_acc_n & r_m[i]) == r_hc[i]) begin
                w_match = 1'b1;
                w_idx   = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= NO_TAB;
            r_acc     <= '0;
            r_len     <= '0;
            sym_valid <= 1'b0;
            sym       <= 3'd0;
            err       <= 1'b0;
            err_type  <= 2'b00;
            dec_count <= '0;
            for (int i = 0; i < 6; i++) begin
                r_hc[i] <= '0;
                r_m[i]  <= '0;
            end
        end else if (code_valid) begin
            for (int i = 0; i < 6; i++) begin
                r_hc[i] <= w_hc_in[i];
                r_m[i]  <= w_m_in[i];
            end
            r_acc     <= '0;
            r_len     <= '0;
            sym_valid <= 1'b0;
            sym       <= 3'd0;
            dec_count <= '0;
            r_state   <= w_tab_ok ? RUN : ERR;
            err       <= !w_tab_ok;
            err_type  <= w_tab_ok ? 2'b00 : 2'b01;
        end else if (r_state == RUN) begin
            if (w_hs) begin
                sym_valid <= 1'b0;
                dec_count <= dec_count + C_ONE;
            end
            if (w_accept) begin
                if (w_match) begin
                    sym       <= w_idx;
                    sym_valid <= 1'b1;
                    r_acc     <= '0;
                    r_len     <= '0;
                end else if (w_len_n == L_MAX) begin
                    r_state  <= ERR;
                    err      <= 1'b1;
                    err_type <= 2'b10;
                    r_acc    <= '0;
                    r_len    <= '0;
                end else begin
                    r_acc <= w_acc_n;
                    r_len <= w_len_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: vector table, directed corner cases,
// and a random symbol stream checked against an encode-side scoreboard.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0] M1, M2, M3, M4, M5, M6;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       sym_valid;
    logic [2:0] sym;
    logic       sym_ready;
    logic       err;
    logic [1:0] err_type;
    logic [7:0] dec_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] t_hc [6];
    logic [7:0] t_m  [6];

    typedef struct {
        logic       b;
        logic       v;
        logic [2:0] s;
    } vec_t;

    huffman_decoder #(.MAXLEN(8), .CW(8)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .err(err), .err_type(err_type), .dec_count(dec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0: basic table, 1: non-contiguous M3, 2: overflow table
    task automatic load_table(input int kind);
        t_hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        t_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
        if (kind == 1) t_m[2] = 8'h05;
        if (kind == 2) begin
            t_hc = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
            t_m  = '{8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        end
        {HC1, HC2, HC3, HC4, HC5, HC6} = {t_hc[0], t_hc[1], t_hc[2],
                                          t_hc[3], t_hc[4], t_hc[5]};
        {M1, M2, M3, M4, M5, M6} = {t_m[0], t_m[1], t_m[2],
                                    t_m[3], t_m[4], t_m[5]};
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs [20];
        int   s, l, es, got, cyc;
        logic qb [$];
        int   exp_q [$];

        vecs = '{
            '{1'b0, 1'b1, 3'd1},
            '{1'b1, 1'b0, 3'd0}, '{1'b0, 1'b1, 3'd2},
            '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0}, '{1'b0, 1'b1, 3'd3},
            '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0},
            '{1'b0, 1'b1, 3'd4},
            '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0},
            '{1'b1, 1'b0, 3'd0}, '{1'b0, 1'b1, 3'd5},
            '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0},
            '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b1, 3'd6}
        };

        reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        sym_ready = 1'b1;
        {HC1, HC2, HC3, HC4, HC5, HC6} = '0;
        {M1, M2, M3, M4, M5, M6} = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym", sym, 0);
        chk("rst_err", err, 0);
        chk("rst_err_type", err_type, 0);
        chk("rst_dec_count", dec_count, 0);

        // basic stream from the vector table
        load_table(0);
        chk("load_bit_ready", bit_ready, 1);
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1;
            bit_in = vecs[i].b;
            step();
            chk("vec_valid", sym_valid, vecs[i].v);
            if (vecs[i].v) chk("vec_sym", sym, vecs[i].s);
        end
        bit_valid = 1'b0;
        step();
        chk("basic_dec_count", dec_count, 6);
        chk("basic_err", err, 0);

        // reload while a symbol is pending; concurrent bit is dropped
        sym_ready = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        step();
        bit_valid = 1'b0;
        step();
        chk("pend_held", sym_valid, 1);
        sym_ready = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
        load_table(0);
        chk("reload_valid", sym_valid, 0);
        chk("reload_dec", dec_count, 0);
        bit_valid = 1'b0;
        step();
        chk("reload_bit_dropped", sym_valid, 0);
        bit_valid = 1'b1; bit_in = 1'b1;
        step();
        bit_in = 1'b0;
        step();
        chk("reload_restart_v", sym_valid, 1);
        chk("reload_restart_s", sym, 2);
        bit_valid = 1'b0;
        step();
        chk("reload_restart_dec", dec_count, 1);

        // backpressure
        load_table(0);
        sym_ready = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        step();
        #1;
        chk("bp_bit_ready", bit_ready, 0);
        step(); step(); step();
        chk("bp_held_v", sym_valid, 1);
        chk("bp_held_s", sym, 1);
        chk("bp_held_dec", dec_count, 0);
        sym_ready = 1'b1;
        step();
        chk("bp_rel1_s", sym, 1);
        chk("bp_rel1_dec", dec_count, 1);
        bit_in = 1'b1;
        step();
        chk("bp_rel2_v", sym_valid, 0);
        chk("bp_rel2_dec", dec_count, 2);
        bit_in = 1'b0;
        step();
        chk("bp_rel3_s", sym, 2);
        bit_valid = 1'b0;
        step();
        chk("bp_dec", dec_count, 3);

        // bad table, then recovery
        load_table(1);
        chk("bad_err", err, 1);
        chk("bad_type", err_type, 1);
        chk("bad_bit_ready", bit_ready, 0);
        bit_valid = 1'b1; bit_in = 1'b0;
        step();
        chk("bad_ignored", sym_valid, 0);
        bit_valid = 1'b0;
        load_table(0);
        chk("fix_err", err, 0);
        chk("fix_bit_ready", bit_ready, 1);

        // no-match overflow after MAXLEN bits
        load_table(2);
        bit_valid = 1'b1; bit_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("ovf_err", err, (i == 8) ? 1 : 0);
            chk("ovf_valid", sym_valid, 0);
        end
        bit_valid = 1'b0;
        chk("ovf_type", err_type, 2);
        chk("ovf_bit_ready", bit_ready, 0);

        // reset in the middle of a codeword
        load_table(0);
        bit_valid = 1'b1; bit_in = 1'b1;
        step(); step();
        bit_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_bit_ready", bit_ready, 0);
        chk("mid_valid", sym_valid, 0);
        chk("mid_sym", sym, 0);
        chk("mid_err", {err, err_type}, 0);
        chk("mid_dec", dec_count, 0);
        load_table(0);
        bit_valid = 1'b1; bit_in = 1'b0;
        step();
        chk("mid_after_v", sym_valid, 1);
        chk("mid_after_s", sym, 1);
        bit_valid = 1'b0;

        // random stream: encode random symbols, expect them back in order
        load_table(0);
        for (int k = 0; k < 300; k++) begin
            s = $urandom_range(1, 6);
            exp_q.push_back(s);
            l = $countones(t_m[s-1]);
            for (int b = l - 1; b >= 0; b--) qb.push_back(t_hc[s-1][b]);
        end
        got = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20000) begin
            bit_valid = (qb.size() > 0) && ($urandom_range(0, 9) < 7);
            bit_in = (qb.size() > 0) ? qb[0] : 1'b0;
            sym_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (bit_valid && bit_ready) void'(qb.pop_front());
            if (sym_valid && sym_ready) begin
                es = exp_q.pop_front();
                chk("rand_sym", sym, es);
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bit_valid = 1'b0;
        sym_ready = 1'b0;
        chk("rand_all_seen", exp_q.size(), 0);
        chk("rand_dec_wrap", dec_count, got % 256);
        chk("rand_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
